// File: rtl/rvm_mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings,
// the read encoding of the byte-enable bus and the wait counter width.
package rvm_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] BEN_READ = 4'b0000;
    localparam int         CNT_W    = 4;

endpackage

// File: rtl/rvm_mem_responder_array.sv
// Word-organised backing store: synchronous byte-enabled write port and a
// registered read port whose output register clears on reset.
module rvm_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage has no reset so its contents survive a reset of the responder.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rvm_mem_responder.sv
// Stalling memory responder for a simple core bus: captures a request,
// waits WAIT_CYCLES, then completes it in a single response cycle.
module rvm_mem_responder
    import rvm_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_c_en,
    input  logic [3:0]  mem_b_en,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_stall
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             capture;
    logic             exec;

    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_ben;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_ben;
    logic [31:0] word_idx;
    logic        acc_err;
    logic        is_read;
    logic        arr_we, arr_re;

    // With zero wait cycles the access executes on the capture edge, so the
    // live bus is used in IDLE and the latched copy everywhere else.
    always_comb begin
        cur_addr  = (state == ST_IDLE) ? mem_addr  : lat_addr;
        cur_wdata = (state == ST_IDLE) ? mem_wdata : lat_wdata;
        cur_ben   = (state == ST_IDLE) ? mem_b_en  : lat_ben;
        word_idx  = (cur_addr - BASE_ADDR) >> 2;
        acc_err   = (cur_addr[1:0] != 2'b00) || (word_idx >= 32'(DEPTH_WORDS));
        is_read   = (cur_ben == BEN_READ);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_c_en) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = ST_RESP;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_c_en) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    state_nx = ST_RESP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign exec      = (state_nx == ST_RESP) && (state != ST_RESP) && !reset;
    assign arr_we    = exec && !is_read && !acc_err;
    assign arr_re    = exec &&  is_read && !acc_err;
    assign mem_stall = mem_c_en && (state != ST_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mem_error <= exec && acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_ben   <= mem_b_en;
        end
    end

    rvm_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .be    (cur_ben),
        .waddr (word_idx[AW-1:0]),
        .wdata (cur_wdata),
        .re    (arr_re),
        .raddr (word_idx[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Bench for rvm_mem_responder: one instance with WAIT_CYCLES=0 and one with
// WAIT_CYCLES=1, checked against a word-array reference model.
module tb_rvm_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        cen   [2];
    logic [3:0]  ben   [2];
    logic [31:0] rdata [2];
    logic        error [2];
    logic        stall [2];

    logic [31:0] mm     [2][DEPTH];
    logic [31:0] exp_rd [2];
    logic [31:0] last_rd;
    logic        last_err;
    int          cmp_cnt  = 0;
    int          fail_cnt = 0;

    always #5 clk = ~clk;

    rvm_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk(clk), .reset(rst[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_c_en(cen[0]), .mem_b_en(ben[0]), .mem_rdata(rdata[0]),
        .mem_error(error[0]), .mem_stall(stall[0]));

    rvm_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .reset(rst[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_c_en(cen[1]), .mem_b_en(ben[1]), .mem_rdata(rdata[1]),
        .mem_error(error[1]), .mem_stall(stall[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request and follows it to completion; c_en stays high so
    // a following call forms a back-to-back access.
    task automatic access(input int i, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input bit scramble);
        logic [31:0] idx;
        bit          err;
        int          ns;
        bit          done;
        idx = (a - BASE) >> 2;
        err = (a[1:0] != 2'b00) || (idx >= DEPTH);
        if (!err && be == 4'b0000) exp_rd[i] = mm[i][idx];
        @(negedge clk);
        addr[i] = a; wdata[i] = wd; ben[i] = be; cen[i] = 1'b1;
        ns = 0; done = 0;
        while (!done && ns <= 40) begin
            #1;
            if (!stall[i]) begin
                done = 1;
            end else begin
                chk("error_while_stalled", {31'b0, error[i]}, 32'd0);
                ns++;
                @(negedge clk);
                if (scramble) begin
                    addr[i]  = $urandom;
                    wdata[i] = $urandom;
                    ben[i]   = 4'($urandom);
                end
            end
        end
        chk("completed", {31'b0, done}, 32'd1);
        chk("stall_cycles", 32'(ns), 32'(i + 1));
        chk("rdata", rdata[i], exp_rd[i]);
        chk("error", {31'b0, error[i]}, {31'b0, err});
        last_rd  = rdata[i];
        last_err = error[i];
        if (!err && be != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mm[i][idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic go_idle(input int i);
        @(negedge clk);
        cen[i] = 1'b0;
        #1;
        chk("idle_error_low", {31'b0, error[i]}, 32'd0);
        chk("idle_stall_low", {31'b0, stall[i]}, 32'd0);
    endtask

    task automatic do_reset(input int i);
        @(negedge clk);
        rst[i] = 1'b1; cen[i] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdata", rdata[i], 32'd0);
        chk("reset_error", {31'b0, error[i]}, 32'd0);
        chk("reset_stall", {31'b0, stall[i]}, 32'd0);
        rst[i] = 1'b0;
        exp_rd[i] = 32'd0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cen[i] = 1'b0; addr[i] = '0; wdata[i] = '0; ben[i] = '0;
            exp_rd[i] = '0;
        end
        do_reset(0);
        do_reset(1);

        // Give the first 64 words of each store known contents.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) access(i, 32'(k) << 2, $urandom, 4'hF, 1'b0);
            go_idle(i);
        end

        // Full-word write then read with one wait cycle.
        access(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0); go_idle(1);
        access(1, 32'h10, 32'h0, 4'h0, 1'b1);        go_idle(1);
        chk("write_read_const", last_rd, 32'hDEADBEEF);

        // Byte-lane merge.
        access(1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0);  go_idle(1);
        access(1, 32'h20, 32'h11223344, 4'b0101, 1'b1); go_idle(1);
        access(1, 32'h20, 32'h0, 4'h0, 1'b0);         go_idle(1);
        chk("lane_merge_const", last_rd, 32'hFF22FF44);

        // Misaligned and out-of-range accesses, then confirm no array change.
        access(1, 32'h22, 32'h0, 4'h0, 1'b0);   go_idle(1);
        chk("misaligned_err", {31'b0, last_err}, 32'd1);
        access(1, 32'h1000, 32'h0, 4'h0, 1'b0); go_idle(1);
        chk("range_err", {31'b0, last_err}, 32'd1);
        chk("range_rdata_kept", last_rd, 32'hFF22FF44);
        access(1, 32'h1000, 32'h12345678, 4'hF, 1'b0); go_idle(1);
        access(1, 32'h22, 32'h12345678, 4'hF, 1'b0);   go_idle(1);
        access(1, 32'h20, 32'h0, 4'h0, 1'b0);          go_idle(1);

        // Abort: drop c_en in the first WAIT cycle of a write.
        @(negedge clk);
        addr[1] = 32'h30; wdata[1] = 32'hA5A5A5A5; ben[1] = 4'hF; cen[1] = 1'b1;
        @(negedge clk);
        cen[1] = 1'b0;
        #1 chk("abort_stall", {31'b0, stall[1]}, 32'd0);
        @(negedge clk);
        #1 chk("abort_no_resp_error", {31'b0, error[1]}, 32'd0);
        chk("abort_rdata_kept", rdata[1], exp_rd[1]);
        access(1, 32'h30, 32'h0, 4'h0, 1'b0); go_idle(1);

        // Reset during WAIT of a write.
        @(negedge clk);
        addr[1] = 32'h14; wdata[1] = 32'h5A5A5A5A; ben[1] = 4'hF; cen[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        #1 chk("midreset_rdata", rdata[1], 32'd0);
        chk("midreset_error", {31'b0, error[1]}, 32'd0);
        cen[1] = 1'b0; rst[1] = 1'b0; exp_rd[1] = 32'd0;
        access(1, 32'h14, 32'h0, 4'h0, 1'b0); go_idle(1);
        access(1, 32'h10, 32'h0, 4'h0, 1'b0); go_idle(1);

        // Back-to-back reads with no wait cycles.
        access(0, 32'h0, 32'h0, 4'h0, 1'b1);
        access(0, 32'h4, 32'h0, 4'h0, 1'b1);
        go_idle(0);

        // Randomised mix of reads, writes, errors and back-to-back requests.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 60; n++) begin
                case ($urandom_range(0, 9))
                    0:       a = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
                    1:       a = 32'h1000 + (32'($urandom_range(0, 4000)) << 2);
                    default: a = 32'($urandom_range(0, 63)) << 2;
                endcase
                be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                access(i, a, $urandom, be, 1'b1);
                if ($urandom_range(0, 2) != 0) go_idle(i);
            end
            go_idle(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
